// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destinations and derives per-operand forward selects and a stall request.
// Optional HAZ_STATS_EN builds saturating stall/forward statistics counters.
module hazard_scoreboard #(
    parameter int NREGS  = 16,
    parameter int REG_W  = $clog2(NREGS),
    parameter int DEPTH  = 2,
    parameter int MD_LAT = 4,
    parameter int SELW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_flush,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_src1_used,
    input  logic             id_src2_used,
    input  logic             id_is_branch,
    input  logic             id_writes,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_is_load,
    input  logic             id_is_md,
    input  logic             id_reads_r0,
    output logic             stall,
    output logic [SELW-1:0]  fwd_sel1,
    output logic [SELW-1:0]  fwd_sel2,
    output logic [31:0]      stall_count,
    output logic [31:0]      fwd_count
);
    localparam int MDW = $clog2(MD_LAT);

    logic [DEPTH:1]   v;
    logic [DEPTH:1]   ld;
    logic [REG_W-1:0] dst [1:DEPTH];
    logic [MDW-1:0]   md_cnt;
    logic [DEPTH:1]   m1;
    logic [DEPTH:1]   m2;
    logic [SELW-1:0]  sel1;
    logic [SELW-1:0]  sel2;
    logic             live;
    logic             accept;
    logic             src_r0;
    logic             hz;

    // Scanning oldest to youngest leaves the youngest match in the select.
    always_comb begin
        m1   = '0;
        m2   = '0;
        sel1 = '0;
        sel2 = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            m1[k] = id_src1_used && v[k] && dst[k] == id_src1 && id_src1 != '0;
            m2[k] = id_src2_used && v[k] && dst[k] == id_src2 && id_src2 != '0;
            if (m1[k]) sel1 = SELW'(k);
            if (m2[k]) sel2 = SELW'(k);
        end
    end

    assign live   = id_valid && !id_flush;
    assign src_r0 = (id_src1_used && id_src1 == '0) || (id_src2_used && id_src2 == '0);
    assign hz     = (ld[1] && (m1[1] || m2[1]))
                  || (id_is_branch && (m1[1] || m2[1] || (ld[2] && (m1[2] || m2[2]))))
                  || (md_cnt != '0 && (id_is_md || id_reads_r0 || src_r0));
    assign stall    = live && hz;
    assign accept   = live && !stall;
    assign fwd_sel1 = stall ? '0 : sel1;
    assign fwd_sel2 = stall ? '0 : sel2;

    always_ff @(posedge clk) begin
        if (rst) begin
            v      <= '0;
            md_cnt <= '0;
        end else begin
            v      <= {v[DEPTH-1:1], accept && id_writes};
            md_cnt <= (accept && id_is_md) ? MDW'(MD_LAT - 1) : (md_cnt != '0) ? md_cnt - 1'b1 : md_cnt;
        end
    end

    always_ff @(posedge clk) begin
        ld     <= {ld[DEPTH-1:1], id_is_load};
        dst[1] <= id_dst;
        for (int k = 2; k <= DEPTH; k++) dst[k] <= dst[k-1];
    end

`ifdef HAZ_STATS_EN
    logic [31:0] sc;
    logic [31:0] fc;
    always_ff @(posedge clk) begin
        if (rst) begin
            sc <= '0;
            fc <= '0;
        end else begin
            if (stall && sc != '1) sc <= sc + 1'b1;
            if ((fwd_sel1 != '0 || fwd_sel2 != '0) && fc != '1) fc <= fc + 1'b1;
        end
    end
    assign stall_count = sc;
    assign fwd_count   = fc;
`else
    assign stall_count = '0;
    assign fwd_count   = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed stimulus with an age-based reference model checked every cycle.
module tb_hazard_scoreboard;
    localparam int DEPTH  = 2;
    localparam int MD_LAT = 4;

    logic       clk = 0;
    logic       rst = 1;
    logic       id_valid = 0, id_flush = 0, id_src1_used = 0, id_src2_used = 0;
    logic       id_is_branch = 0, id_writes = 0, id_is_load = 0, id_is_md = 0, id_reads_r0 = 0;
    logic [3:0] id_src1 = 0, id_src2 = 0, id_dst = 0;
    logic       stall;
    logic [1:0] fwd_sel1, fwd_sel2;
    logic [31:0] stall_count, fwd_count;

    hazard_scoreboard #(.NREGS(16), .DEPTH(DEPTH), .MD_LAT(MD_LAT)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_flush(id_flush),
        .id_src1(id_src1), .id_src2(id_src2), .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .id_is_branch(id_is_branch), .id_writes(id_writes), .id_dst(id_dst), .id_is_load(id_is_load),
        .id_is_md(id_is_md), .id_reads_r0(id_reads_r0), .stall(stall), .fwd_sel1(fwd_sel1),
        .fwd_sel2(fwd_sel2), .stall_count(stall_count), .fwd_count(fwd_count)
    );

    always #5 clk = ~clk;

    int pass = 0, total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: producers carry their age (1 = EX); a value is usable once the producer is old enough.
    typedef struct {int dst; bit ld; int age;} ent_t;
    ent_t q[$];
    int   cyc = 0, md_acc = -100, m_sc = 0, m_fc = 0;
    bit   started = 0;

    function automatic bit not_ready(input bit used, input int s);
        int need;
        need = id_is_branch ? 2 : 1;
        if (!used || s == 0) return 0;
        foreach (q[i]) if (q[i].dst == s && q[i].age < need + (q[i].ld ? 1 : 0)) return 1;
        return 0;
    endfunction

    function automatic int youngest(input bit used, input int s);
        int best = 0;
        if (!used || s == 0) return 0;
        foreach (q[i]) if (q[i].dst == s && (best == 0 || q[i].age < best)) best = q[i].age;
        return best;
    endfunction

    function automatic void model_out(output bit st, output int f1, output int f2);
        bit md_busy, r0_use;
        md_busy = cyc > md_acc && cyc < md_acc + MD_LAT;
        r0_use  = id_is_md || id_reads_r0 || (id_src1_used && id_src1 == 0) || (id_src2_used && id_src2 == 0);
        st = id_valid && !id_flush && (not_ready(id_src1_used, int'(id_src1)) ||
             not_ready(id_src2_used, int'(id_src2)) || (md_busy && r0_use));
        f1 = st ? 0 : youngest(id_src1_used, int'(id_src1));
        f2 = st ? 0 : youngest(id_src2_used, int'(id_src2));
    endfunction

    always @(posedge clk) begin
        bit st;
        int f1, f2;
        model_out(st, f1, f2);
        if (rst) begin
            q.delete();
            md_acc = -100;
            cyc = 0;
            m_sc = 0;
            m_fc = 0;
        end else begin
            m_sc += int'(st);
            m_fc += int'(f1 != 0 || f2 != 0);
            foreach (q[i]) q[i].age++;
            for (int i = q.size() - 1; i >= 0; i--) if (q[i].age > DEPTH) q.delete(i);
            if (id_valid && !id_flush && !st) begin
                if (id_writes) q.push_back('{int'(id_dst), id_is_load, 1});
                if (id_is_md) md_acc = cyc;
            end
            cyc++;
        end
        started = 1;
    end

    always @(negedge clk) begin
        bit st;
        int f1, f2;
        if (started) begin
            model_out(st, f1, f2);
            chk("stall", stall, st);
            chk("fwd_sel1", fwd_sel1, f1);
            chk("fwd_sel2", fwd_sel2, f2);
`ifdef HAZ_STATS_EN
            chk("stall_count", stall_count, m_sc);
            chk("fwd_count", fwd_count, m_fc);
`else
            chk("stall_count", stall_count, 0);
            chk("fwd_count", fwd_count, 0);
`endif
        end
    end

    task automatic op(input bit br, wr, ld, md, r0, input int dst, s1, s2,
                      input bit u1 = 1, u2 = 1, v = 1, f = 0);
        @(posedge clk);
        #1;
        id_valid = v; id_flush = f; id_is_branch = br; id_writes = wr; id_is_load = ld;
        id_is_md = md; id_reads_r0 = r0; id_dst = 4'(dst); id_src1 = 4'(s1); id_src2 = 4'(s2);
        id_src1_used = u1; id_src2_used = u2;
        #2;
    endtask

    task automatic alu(input int d, s1, s2); op(0, 1, 0, 0, 0, d, s1, s2); endtask
    task automatic load(input int d, s1); op(0, 1, 1, 0, 0, d, s1, 0, 1, 0); endtask
    task automatic branch(input int s1, s2); op(1, 0, 0, 0, 0, 0, s1, s2); endtask
    task automatic idle(); op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

    task automatic pulse_rst();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        #2;
        chk("reset stall", stall, 0);
        chk("reset fwd1", fwd_sel1, 0);
        chk("reset stall_count", stall_count, 0);
        chk("reset fwd_count", fwd_count, 0);

        alu(3, 1, 2);
        alu(6, 3, 9);
        chk("alu-alu stall", stall, 0);
        chk("alu-alu fwd1", fwd_sel1, 1);
        alu(8, 3, 9);
        chk("alu age2 fwd1", fwd_sel1, 2);
        idle(); idle();

        load(5, 1);
        alu(10, 1, 5);
        chk("load-use stall", stall, 1);
        chk("load-use fwd2 suppressed", fwd_sel2, 0);
        alu(10, 1, 5);
        chk("load-use after stall", stall, 0);
        chk("load-use fwd2", fwd_sel2, 2);
        idle(); idle();

        load(7, 1);
        branch(7, 2);
        chk("br-load stall 1", stall, 1);
        branch(7, 2);
        chk("br-load stall 2", stall, 1);
        branch(7, 2);
        chk("br-load released", stall, 0);
        chk("br-load fwd1", fwd_sel1, 0);
        alu(3, 1, 2);
        branch(3, 2);
        chk("br-alu stall", stall, 1);
        branch(3, 2);
        chk("br-alu fwd1", fwd_sel1, 2);
        idle(); idle();

        alu(0, 1, 2);
        alu(3, 0, 1);
        chk("src0 no fwd", fwd_sel1, 0);
        idle(); idle();
        op(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < MD_LAT - 1; i++) begin
            op(1, 0, 0, 0, 1, 0, 0, 3);
            chk("md busy stall", stall, 1);
        end
        op(1, 0, 0, 0, 1, 0, 0, 3);
        chk("md done", stall, 0);
        chk("md r0 fwd", fwd_sel1, 0);
        idle(); idle();

        alu(4, 1, 2);
        alu(4, 2, 1);
        alu(11, 4, 1);
        chk("youngest wins", fwd_sel1, 1);
        idle(); idle();

        load(5, 1);
        op(0, 1, 0, 0, 0, 14, 1, 5, 1, 1, 1, 1);
        chk("flush no stall", stall, 0);
        alu(9, 14, 5);
        chk("flushed not tracked", fwd_sel1, 0);
        chk("flush then fwd2", fwd_sel2, 2);
        load(12, 1);
        op(0, 0, 0, 0, 0, 0, 12, 0, 1, 0, 0);
        chk("invalid no stall", stall, 0);
        idle(); idle();

        load(12, 1);
        alu(13, 12, 1);
        chk("pre-reset stall", stall, 1);
        pulse_rst();
        chk("post-reset stall", stall, 0);
        chk("post-reset fwd1", fwd_sel1, 0);
        idle();

        pulse_rst();
        load(5, 1);
        alu(10, 1, 5);
        alu(10, 1, 5);
        load(7, 1);
        branch(7, 2);
        branch(7, 2);
        branch(7, 2);
        alu(15, 1, 2);
        alu(9, 15, 2);
        idle();
`ifdef HAZ_STATS_EN
        chk("stats stall_count", stall_count, 3);
        chk("stats fwd_count", fwd_count, 2);
`else
        chk("stats stall_count", stall_count, 0);
        chk("stats fwd_count", fwd_count, 0);
`endif
        idle();
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the fixed-pattern hazard detector: a scoreboard that tracks in-flight destination registers across a configurable number of downstream pipeline stages and produces per-operand forwarding selects and a stall request. Sits beside the decode (ID) stage. It replaces hard-coded per-opcode hazard bits with generic decoded flags. It adds a multi-cycle mult/div busy counter, so that R0 consumers stall until the MD result is written.

## Interface
- `NREGS`, default 16: architectural register count; register 0 is the implicit MD destination R0.
- `REG_W`, default 4: register index width; `$clog2(NREGS)`.
- `DEPTH`, default 2: number of tracked downstream stages. Legal values are 2 to 6. Stage 1 is EX.
- `MD_LAT`, default 4: mult/div latency in cycles, ≥2.
- `SELW`, derived as `$clog2(DEPTH+1)`: width of the forward selects.

Ports:
- `clk`  in  1  clock. Everything happens on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  the ID stage holds a real instruction.
- `id_flush`  in  1  squash the ID instruction. It is treated as a bubble.
- `id_src1`, `id_src2`  in  REG_W  source register indices.
- `id_src1_used`, `id_src2_used`  in  1  the corresponding source is actually read.
- `id_is_branch`  in  1  branch; operands are needed in ID.
- `id_writes`  in  1  the instruction writes `id_dst`.
- `id_dst`  in  REG_W  destination index.
- `id_is_load`  in  1  load; its result is available at the end of stage 2.
- `id_is_md`  in  1  mult/div; it implicitly writes R0 after MD_LAT cycles.
- `id_reads_r0`  in  1  implicit R0 read, e.g. a branch that compares against R0.
- `stall`  out  1  hold PC and ID, and inject a bubble into EX.
- `fwd_sel1`, `fwd_sel2`  out  SELW  0 selects the register file; k selects the result of stage k.
- `stall_count`, `fwd_count`  out  32  statistics counters. See Configuration.

## Operation
- The scoreboard is a shift register of DEPTH entries. Each entry holds {valid, dst, is_load}.
- Each cycle, entries k move to k+1 and entry DEPTH is dropped.
- Entry 1 loads the ID instruction when `id_valid && !id_flush && !stall && id_writes`. Otherwise entry 1 loads a bubble (valid=0).
- A source s "matches" entry k when: the source is used, entry k is valid, `dst==s`, and `s!=0`.
- Forwarding:
  - `fwd_selN` is the lowest k that matches; this is the youngest-wins priority rule.
  - If no entry matches, `fwd_selN` is 0.
  - Forwarding is suppressed (0) whenever `stall` is asserted.
- Stall conditions (OR of all):
  - Load-use: entry 1 is a load and matches a used source.
  - Branch-early: `id_is_branch` and entry 1 matches a used source. A branch also stalls when entry 2 is a load that matches a source.
  - MD busy: `md_cnt != 0` and any of `id_is_md`, `id_reads_r0`, or a used source equal to 0.
- MD counter:
  - When an MD instruction is accepted (`id_is_md && id_valid && !id_flush && !stall`), `md_cnt` loads MD_LAT-1.
  - Otherwise, if `md_cnt != 0`, it decrements by 1.
  - The R0 write retires in the cycle `md_cnt` reaches 0. The register file is write-through, so the consumer reads source 0 with `fwd_sel=0`.
- `stall` and `fwd_sel*` are combinational from the current state and the ID inputs.
- When `id_valid=0` or `id_flush=1`, `stall` is 0.

## Timing
- Reset, while `rst`=1 at a rising edge:
  - all entries are invalid and `md_cnt`=0;
  - `stall`=0, `fwd_sel1`=`fwd_sel2`=0;
  - both stat counters are 0.
- Latency:
  - The stall decision is in the same cycle (zero latency). The scoreboard updates at the next edge.
  - A load-use dependence stalls exactly 1 cycle. In the following cycle `fwd_sel` selects 2.
  - A branch after an ALU op stalls 1 cycle, then forwards from 2.
  - A branch after a load stalls 2 cycles.
  - An R0 consumer issued the cycle after an MD stalls MD_LAT-1 cycles.
- Simultaneous events:
  - A flush in the same cycle as a hazard gives `stall`=0 and a bubble is inserted.
  - An MD accept never overlaps a busy counter, because of the MD-busy stall.
- Reset asserted mid-stall clears all state. The next cycle sees no hazards.

## Configuration
- `HAZ_STATS_EN` defined:
  - `stall_count` increments every cycle `stall`=1.
  - `fwd_count` increments every cycle either `fwd_sel` is nonzero, by 1 per cycle (not per operand).
  - Both counters saturate at 2^32-1 and are cleared by `rst`.
- `HAZ_STATS_EN` undefined: both ports are tied to 0 and no counter flops are built.

## Test plan
- ALU `r3←` followed by an ALU reading r3 as src1 gives `stall`=0 and `fwd_sel1`=1. One cycle later, another r3 reader gets `fwd_sel1`=2.
- Load `r5←` followed by an ALU reading r5 as src2 gives `stall`=1 for 1 cycle, then `fwd_sel2`=2 and `stall`=0.
- Load `r7←`, then a branch on r7/r2, gives `stall`=1 for 2 cycles, then `fwd_sel1`=0 (value comes from the register file).
- With MD_LAT=4: MD, then an immediate branch with `id_reads_r0` gives `stall`=1 for 3 cycles, then 0. A source of 0 never produces a forward.
- Two writers to r4 in entries 1 and 2, then a reader of r4 gives `fwd_sel1`=1 (youngest wins). Asserting `rst` during a load-use stall drops `stall` to 0 and leaves the scoreboard empty next cycle.
- With `HAZ_STATS_EN`: 3 stall cycles and 2 forward cycles give `stall_count`=3 and `fwd_count`=2.
